// File: rtl/cmp_share_pkg.sv
// cmp_share_pkg
// Shared definitions for the comparator-sharing arbiter:
//   - state_t      : arbiter FSM state encoding (IDLE, CMP, RSP)
//   - STAT_W       : width of the optional per-class response counters
//   - rr_pick_fn   : round-robin search over a request vector (up to 16 lanes)
// No ports; imported by rr_pick and cmp_share_arbiter.
package cmp_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam int STAT_W = 16;

    // Returns {found, index}. The search starts at ptr and wraps modulo n,
    // so the lane right after the last winner gets first chance next time.
    // Lanes at or above n are never considered.
    function automatic logic [4:0] rr_pick_fn(input logic [15:0] valid,
                                              input logic [3:0]  ptr,
                                              input int          n);
        logic       found;
        logic [3:0] idx;
        int         k;
        found = 1'b0;
        idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (i < n && !found) begin
                k = (int'(ptr) + i) % n;
                if (valid[k[3:0]]) begin
                    found = 1'b1;
                    idx   = k[3:0];
                end
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/cmp_share_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin priority rotator used for grant generation.
// Ports:
//   valid : NUM_REQ request lines
//   ptr   : ID_W-bit index that has highest priority this cycle
//   grant : one-hot grant (all zeros when nothing is valid)
//   idx   : binary index of the granted lane
//   found : at least one lane is valid
module rr_pick
    import cmp_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    logic [4:0] pick;

    always_comb begin
        pick  = rr_pick_fn(16'(valid), 4'(ptr), NUM_REQ);
        found = pick[4];
        idx   = ID_W'(pick[3:0]);
        grant = found ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/comparator.sv
// comparator
// Combinational magnitude comparator.
// Ports:
//   A, B    : WIDTH-bit unsigned operands
//   equal   : A == B
//   lesser  : A <  B
//   greater : A >  B
module comparator #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             equal,
    output logic             lesser,
    output logic             greater
);

    assign equal   = (A == B);
    assign lesser  = (A <  B);
    assign greater = (A >  B);

endmodule

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter
// Shares one combinational comparator among NUM_REQ requesters. A round-robin
// FSM (IDLE -> CMP -> RSP) grants one requester, registers its operands,
// registers the comparison result and returns it tagged with the requester ID.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (req_ready one-hot, IDLE only)
//   req_a, req_b         : packed operands, slice i = [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready  : response handshake
//   rsp_id               : requester index of the response
//   rsp_eq/rsp_lt/rsp_gt : registered comparison result
//   busy                 : FSM not in IDLE
// Optional (macro CMP_SHARE_STATS_EN):
//   stat_eq/stat_lt/stat_gt : saturating counts of completed responses per class
module cmp_share_arbiter
    import cmp_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_eq,
    output logic                     rsp_lt,
    output logic                     rsp_gt,
    output logic                     busy
`ifdef CMP_SHARE_STATS_EN
    ,
    output logic [STAT_W-1:0]        stat_eq,
    output logic [STAT_W-1:0]        stat_lt,
    output logic [STAT_W-1:0]        stat_gt
`endif
);

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    cur_id;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;

    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_found;
    logic               cmp_eq;
    logic               cmp_lt;
    logic               cmp_gt;
    logic [ID_W-1:0]    rr_next;

    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_pick (
        .valid(req_valid),
        .ptr  (rr_ptr),
        .grant(pick_grant),
        .idx  (pick_idx),
        .found(pick_found)
    );

    comparator #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .A      (op_a),
        .B      (op_b),
        .equal  (cmp_eq),
        .lesser (cmp_lt),
        .greater(cmp_gt)
    );

    // Acceptance is only offered while idle, so the grant can never change
    // the operands of a transaction already in flight.
    assign req_ready = (state == IDLE) ? pick_grant : '0;
    assign busy      = (state != IDLE);

    // Priority moves to the lane after the one just served.
    assign rr_next = (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + ID_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_id    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_eq    <= 1'b0;
            rsp_lt    <= 1'b0;
            rsp_gt    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        op_a   <= req_a[pick_idx*WIDTH +: WIDTH];
                        op_b   <= req_b[pick_idx*WIDTH +: WIDTH];
                        cur_id <= pick_idx;
                        state  <= CMP;
                    end
                end
                CMP: begin
                    rsp_eq    <= cmp_eq;
                    rsp_lt    <= cmp_lt;
                    rsp_gt    <= cmp_gt;
                    rsp_id    <= cur_id;
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= rr_next;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef CMP_SHARE_STATS_EN
    logic rsp_fire;
    assign rsp_fire = (state == RSP) && rsp_valid && rsp_ready;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_eq <= '0;
            stat_lt <= '0;
            stat_gt <= '0;
        end else if (rsp_fire) begin
            if (rsp_eq && stat_eq != '1) stat_eq <= stat_eq + STAT_W'(1);
            if (rsp_lt && stat_lt != '1) stat_lt <= stat_lt + STAT_W'(1);
            if (rsp_gt && stat_gt != '1) stat_gt <= stat_gt + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter
// Self-checking bench for cmp_share_arbiter: directed scenarios followed by
// randomized requester traffic, all compared against a transaction-level
// reference model of the arbiter.
module tb_cmp_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic                     rsp_eq;
    logic                     rsp_lt;
    logic                     rsp_gt;
    logic                     busy;
`ifdef CMP_SHARE_STATS_EN
    logic [15:0]              stat_eq;
    logic [15:0]              stat_lt;
    logic [15:0]              stat_gt;
`endif

    // Requester-side state: which lanes have a pending request and their operands.
    logic                     pend [NUM_REQ];
    logic [WIDTH-1:0]         pa   [NUM_REQ];
    logic [WIDTH-1:0]         pb   [NUM_REQ];
    logic                     rdy;
    logic                     rearm;

    // Reference model: phase of the shared comparator (0 idle, 1 comparing,
    // 2 response offered), priority pointer and the transaction in flight.
    int                       m_phase;
    int                       m_ptr;
    int                       m_id;
    logic [WIDTH-1:0]         m_a;
    logic [WIDTH-1:0]         m_b;
    int                       n_eq, n_lt, n_gt;
    int                       grants_seen;

    int                       errors = 0;
    int                       checks = 0;

    cmp_share_arbiter #(
        .NUM_REQ(NUM_REQ),
        .WIDTH  (WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_eq   (rsp_eq),
        .rsp_lt   (rsp_lt),
        .rsp_gt   (rsp_gt),
        .busy     (busy)
`ifdef CMP_SHARE_STATS_EN
        ,
        .stat_eq  (stat_eq),
        .stat_lt  (stat_lt),
        .stat_gt  (stat_gt)
`endif
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives the requester arrays and response ready onto the DUT pins.
    task automatic applyStimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]              = pend[i];
            req_a[i*WIDTH +: WIDTH]   = pa[i];
            req_b[i*WIDTH +: WIDTH]   = pb[i];
        end
        rsp_ready = rdy;
    endtask

    // Loads a new request on one lane.
    task automatic postReq(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
    endtask

    // Random requester behaviour: occasionally start, rarely withdraw.
    task automatic randomUpdate();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i]) begin
                if ($urandom_range(0, 2) == 0) begin
                    pa[i]   = WIDTH'($urandom);
                    pb[i]   = ($urandom_range(0, 3) == 0) ? pa[i] : WIDTH'($urandom);
                    pend[i] = 1'b1;
                end
            end else if ($urandom_range(0, 31) == 0) begin
                pend[i] = 1'b0;
            end
        end
        rdy = ($urandom_range(0, 3) != 0);
    endtask

    // Called at a falling edge with inputs already driven: compares the DUT
    // against the model, advances the model over the coming rising edge,
    // and returns at the next falling edge.
    task automatic stepCycle();
        int               g;
        logic [NUM_REQ-1:0] exp_ready;
        #1;
        g         = -1;
        exp_ready = '0;
        if (m_phase == 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (m_ptr + k) % NUM_REQ;
                if (g < 0 && pend[i]) g = i;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
        checkOutput("busy", 32'(busy), 32'(m_phase != 0));
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
        if (m_phase == 2) begin
            checkOutput("rsp_id", 32'(rsp_id), 32'(m_id));
            checkOutput("rsp_eq", 32'(rsp_eq), 32'(m_a == m_b));
            checkOutput("rsp_lt", 32'(rsp_lt), 32'(m_a < m_b));
            checkOutput("rsp_gt", 32'(rsp_gt), 32'(m_a > m_b));
        end
        case (m_phase)
            0: if (g >= 0) begin
                m_id    = g;
                m_a     = pa[g];
                m_b     = pb[g];
                pend[g] = 1'b0;
                m_phase = 1;
                grants_seen++;
            end
            1: m_phase = 2;
            default: if (rdy) begin
                if (m_a == m_b) n_eq++;
                else if (m_a < m_b) n_lt++;
                else n_gt++;
                m_ptr   = (m_id + 1) % NUM_REQ;
                m_phase = 0;
            end
        endcase
        @(posedge clk);
        @(negedge clk);
        if (rearm) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!pend[i]) postReq(i, WIDTH'($urandom), WIDTH'($urandom));
        end
    endtask

    // Runs n cycles with the current requester/ready settings.
    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) begin
            applyStimulus();
            stepCycle();
        end
    endtask

    // Synchronous reset for one edge, then checks every output is cleared.
    task automatic doReset();
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        rst_n = 1'b0;
        applyStimulus();
        @(posedge clk);
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("rst_rsp_flags", 32'({rsp_eq, rsp_lt, rsp_gt}), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        m_phase = 0;
        m_ptr   = 0;
        n_eq    = 0;
        n_lt    = 0;
        n_gt    = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed scenarios followed by random traffic.
    initial begin
        rst_n     = 1'b0;
        rdy       = 1'b1;
        rearm     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        grants_seen = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 1'b0;
            pa[i]   = '0;
            pb[i]   = '0;
        end
        @(negedge clk);
        doReset();

        // Single request on lane 0, 5 vs 2: greater, response two cycles later.
        postReq(0, 4'd5, 4'd2);
        runCycles(5);

        // Lane 2: equal, then lesser.
        postReq(2, 4'd12, 4'd12);
        runCycles(4);
        postReq(2, 4'd3, 4'd12);
        runCycles(4);

        // All lanes requesting from reset: rotation 0,1,2,3,0.
        doReset();
        rearm = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) postReq(i, WIDTH'($urandom), WIDTH'($urandom));
        runCycles(15);
        rearm = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        runCycles(4);

        // Backpressure: response held for several cycles with another lane waiting.
        postReq(3, 4'd9, 4'd1);
        rdy = 1'b0;
        runCycles(2);
        postReq(1, 4'd4, 4'd4);
        runCycles(6);
        rdy = 1'b1;
        runCycles(6);

        // Reset while a response is pending, then lane 1 served normally.
        postReq(1, 4'd7, 4'd8);
        rdy = 1'b0;
        runCycles(4);
        doReset();
        rdy = 1'b1;
        postReq(1, 4'd2, 4'd14);
        runCycles(5);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            randomUpdate();
            applyStimulus();
            stepCycle();
        end
        rdy = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        runCycles(4);

`ifdef CMP_SHARE_STATS_EN
        checkOutput("stat_eq", 32'(stat_eq), 32'(n_eq));
        checkOutput("stat_lt", 32'(stat_lt), 32'(n_lt));
        checkOutput("stat_gt", 32'(stat_gt), 32'(n_gt));
`endif
        checkOutput("grants_nonzero", 32'(grants_seen > 20), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmp_share_arbiter.md
Name: cmp_share_arbiter

Overview:
- Shares one instance of the team's combinational `comparator` (ports A, B, equal, lesser, greater) among NUM_REQ requesters.
- Requesters use a valid/ready handshake to submit operand pairs.
- A round-robin FSM grants one requester at a time, registers its operands and drives the comparator.
- Results return on a single response channel tagged with the requester ID, under a valid/ready handshake.

Parameters:
- NUM_REQ, 4, number of requesters; 2..16.
- WIDTH, 4, operand width; must match the comparator instance.
- ID_W, $clog2(NUM_REQ), width of the requester ID field (localparam).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  one-hot acceptance; a requester's operands are taken on the cycle req_valid[i] && req_ready[i].
- req_a  input  NUM_REQ*WIDTH  packed A operands; slice i = [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  packed B operands, same packing as req_a.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester the response belongs to.
- rsp_eq  output  1  registered comparator `equal`.
- rsp_lt  output  1  registered comparator `lesser` (A<B).
- rsp_gt  output  1  registered comparator `greater` (A>B).
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n==0 at a clk edge):
  - state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0.
  - rsp_id=0, rsp_eq=0, rsp_lt=0, rsp_gt=0, busy=0.
  - Operand registers cleared to 0.
  - Reset mid-operation aborts silently; any pending response is dropped.
- FSM states: IDLE, CMP, RSP.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around modulo NUM_REQ.
  - req_ready is combinational: one-hot on the grant, only in IDLE; all zeros when no request is valid.
  - On grant: capture req_a/req_b slice into op_a/op_b, capture grant index into cur_id, go to CMP.
  - No valid request: stay in IDLE.
- CMP (exactly 1 cycle):
  - Comparator driven from op_a/op_b.
  - At clock end: equal/lesser/greater registered into rsp_eq/lt/gt, cur_id into rsp_id, rsp_valid<=1.
  - Go to RSP.
- RSP:
  - Hold rsp_valid and all rsp_* stable until rsp_valid && rsp_ready.
  - On that handshake: rsp_valid<=0, rr_ptr<=(cur_id+1) mod NUM_REQ, go to IDLE.
  - Backpressure of any length is legal.
- Latency:
  - Accept at cycle T -> rsp_valid first high at T+2.
  - With rsp_ready held high, response completes at T+2; next accept at T+3.
  - Throughput: 1 request per 3 cycles.
- Invariant: exactly one of rsp_eq/rsp_lt/rsp_gt is 1 while rsp_valid=1.
- Requesters: may drop req_valid before acceptance (no penalty); non-granted requesters see req_ready=0 and must hold their operands.
- Simultaneous requests: at most one grant per IDLE cycle; rotating pointer guarantees no starvation (worst-case wait NUM_REQ-1 grants).
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
- Macro: CMP_SHARE_STATS_EN.
- Defined:
  - Adds output ports stat_eq, stat_lt, stat_gt, each 16 bits.
  - Each counts completed response handshakes of its class and saturates at 16'hFFFF.
  - All three clear to 0 on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cmp_share_pkg:
  - FSM state enum (IDLE=2'd0, CMP=2'd1, RSP=2'd2).
  - STAT_W=16.
  - A round-robin pick function (valid vector, pointer -> index, found flag).
- Sub-modules:
  - The existing `comparator` is instantiated as the datapath.
  - One natural new sub-module: rr_pick (combinational priority rotator, NUM_REQ-parameterized), reused for grant generation.

Test Plan:
- Single request: req 0, A=5, B=2, rsp_ready=1 -> req_ready[0] at T, rsp_valid at T+2 with rsp_id=0, gt=1, eq=0, lt=0.
- Equal/less via requester 2: A=12, B=12 -> eq=1, rsp_id=2; then A=3, B=12 -> lt=1.
- Contention: all 4 req_valid high from reset -> grant order 0,1,2,3,0; one acceptance every 3 cycles; never two req_ready bits high.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, busy=1, req_ready=0; release -> completes, next grant on the following cycle.
- Reset mid-op: assert rst_n=0 in RSP -> next cycle all outputs 0, state IDLE, rr_ptr=0; request 1 afterwards is served normally.
- CMP_SHARE_STATS_EN:
  - Issue 3 gt, 2 eq, 1 lt responses -> stat_gt=3, stat_eq=2, stat_lt=1.
  - Force stat_gt near 16'hFFFF -> holds at 16'hFFFF.
